// File: rtl/counter_bank_ctrl_pkg.sv
// Shared widths, opcodes, counter types and slot record for the PLC counter bank.
package counter_bank_ctrl_pkg;

    localparam int TC_ACC_LEN    = 8;
    localparam int TC_PRESET_LEN = 8;
    localparam int TC_TYPE_LEN   = 2;

    localparam logic [TC_TYPE_LEN-1:0] COUNTER_TYPE_UP   = 2'b01;
    localparam logic [TC_TYPE_LEN-1:0] COUNTER_TYPE_DOWN = 2'b10;

    typedef enum logic [1:0] {
        OP_CONFIG = 2'b00,
        OP_COUNT  = 2'b01,
        OP_RST    = 2'b10,
        OP_READ   = 2'b11
    } cb_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } cb_state_e;

    typedef struct packed {
        logic [TC_TYPE_LEN-1:0]   typ;
        logic [TC_PRESET_LEN-1:0] preset;
        logic [TC_ACC_LEN-1:0]    acc;
        logic                     dn;
        logic                     cu;
        logic                     cd;
        logic                     prev;
    } slot_t;

    function automatic logic type_defined(input logic [TC_TYPE_LEN-1:0] t);
        return (t == COUNTER_TYPE_UP) || (t == COUNTER_TYPE_DOWN);
    endfunction

    // Presets are compared at accumulator width, zero-extended or truncated.
    function automatic logic [TC_ACC_LEN-1:0] preset_to_acc(input logic [TC_PRESET_LEN-1:0] p);
        return TC_ACC_LEN'(p);
    endfunction

endpackage

// File: rtl/counter_bank_ctrl_step.sv
// Combinational step datapath: applies one command to one counter slot.
module counter_step
    import counter_bank_ctrl_pkg::*;
(
    input  cb_op_e                   op,
    input  logic [TC_TYPE_LEN-1:0]   cmd_type,
    input  logic [TC_PRESET_LEN-1:0] cmd_preset,
    input  logic                     en,
    input  slot_t                    slot_in,
    output slot_t                    slot_out,
    output logic                     err
);

    logic                  is_up;
    logic                  defined;
    logic                  rise;
    logic [TC_ACC_LEN-1:0] preset_acc;
    logic [TC_ACC_LEN-1:0] acc_inc;
    logic [TC_ACC_LEN-1:0] acc_dec;

    always_comb begin
        slot_out   = slot_in;
        err        = 1'b0;
        is_up      = (slot_in.typ == COUNTER_TYPE_UP);
        defined    = type_defined(slot_in.typ);
        rise       = en && !slot_in.prev;
        preset_acc = preset_to_acc(slot_in.preset);
        acc_inc    = (slot_in.acc == '1) ? slot_in.acc : slot_in.acc + 1'b1;
        acc_dec    = (slot_in.acc == '0) ? slot_in.acc : slot_in.acc - 1'b1;

        case (op)
            OP_CONFIG: begin
                if (type_defined(cmd_type)) begin
                    slot_out.typ    = cmd_type;
                    slot_out.preset = cmd_preset;
                    slot_out.acc    = (cmd_type == COUNTER_TYPE_UP) ? '0 : preset_to_acc(cmd_preset);
                    slot_out.dn     = 1'b0;
                    slot_out.cu     = 1'b0;
                    slot_out.cd     = 1'b0;
                    slot_out.prev   = 1'b0;
                end else begin
                    err = 1'b1;
                end
            end
            OP_COUNT: begin
                if (!defined) begin
                    err = 1'b1;
                end else begin
                    slot_out.prev = en;
                    slot_out.cu   = is_up && en;
                    slot_out.cd   = !is_up && en;
                    // DN only ever sets here; it clears through RST or CONFIG.
                    if (rise && is_up) begin
                        slot_out.acc = acc_inc;
                        slot_out.dn  = slot_in.dn || (acc_inc >= preset_acc);
                    end else if (rise) begin
                        slot_out.acc = acc_dec;
                        slot_out.dn  = slot_in.dn || (acc_dec == '0);
                    end
                end
            end
            OP_RST: begin
                if (!defined) begin
                    err = 1'b1;
                end else begin
                    slot_out.acc  = is_up ? '0 : preset_acc;
                    slot_out.dn   = 1'b0;
                    slot_out.cu   = 1'b0;
                    slot_out.cd   = 1'b0;
                    slot_out.prev = 1'b0;
                end
            end
            default: begin
                err = !defined;
            end
        endcase
    end

endmodule

// File: rtl/counter_bank_ctrl.sv
// Counter bank controller: slot storage plus an IDLE/EXEC/RESP command sequencer.
module counter_bank_ctrl
    import counter_bank_ctrl_pkg::*;
#(
    parameter int NUM_CNT = 8,
    parameter int IDX_W   = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_op,
    input  logic [IDX_W-1:0]         cmd_idx,
    input  logic [TC_TYPE_LEN-1:0]   cmd_type,
    input  logic [TC_PRESET_LEN-1:0] cmd_preset,
    input  logic                     cmd_en,
    output logic                     rsp_valid,
    output logic [TC_ACC_LEN-1:0]    rsp_acc,
    output logic                     rsp_dn,
    output logic                     rsp_cu,
    output logic                     rsp_cd,
    output logic                     rsp_err,
    output logic [NUM_CNT-1:0]       dn_vec
);

    cb_state_e                state_q, state_d;
    cb_op_e                   op_q, op_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [TC_TYPE_LEN-1:0]   type_q, type_d;
    logic [TC_PRESET_LEN-1:0] preset_q, preset_d;
    logic                     en_q, en_d;
    slot_t                    slot_q [NUM_CNT];
    slot_t                    slot_d [NUM_CNT];
    slot_t                    rsp_slot_q, rsp_slot_d;
    logic                     rsp_err_q, rsp_err_d;
    slot_t                    step_out;
    logic                     step_err;

    counter_step u_step (
        .op         (op_q),
        .cmd_type   (type_q),
        .cmd_preset (preset_q),
        .en         (en_q),
        .slot_in    (slot_q[idx_q]),
        .slot_out   (step_out),
        .err        (step_err)
    );

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        idx_d      = idx_q;
        type_d     = type_q;
        preset_d   = preset_q;
        en_d       = en_q;
        slot_d     = slot_q;
        rsp_slot_d = rsp_slot_q;
        rsp_err_d  = rsp_err_q;
        cmd_ready  = (state_q == ST_IDLE);
        rsp_valid  = (state_q == ST_RESP);

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d     = cb_op_e'(cmd_op);
                    idx_d    = cmd_idx;
                    type_d   = cmd_type;
                    preset_d = cmd_preset;
                    en_d     = cmd_en;
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                slot_d[idx_q] = step_out;
                rsp_slot_d    = step_out;
                rsp_err_d     = step_err;
                state_d       = ST_RESP;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_CONFIG;
            idx_q      <= '0;
            type_q     <= '0;
            preset_q   <= '0;
            en_q       <= 1'b0;
            rsp_slot_q <= '0;
            rsp_err_q  <= 1'b0;
            for (int i = 0; i < NUM_CNT; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            idx_q      <= idx_d;
            type_q     <= type_d;
            preset_q   <= preset_d;
            en_q       <= en_d;
            rsp_slot_q <= rsp_slot_d;
            rsp_err_q  <= rsp_err_d;
            slot_q     <= slot_d;
        end
    end

    always_comb begin
        dn_vec = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            dn_vec[i] = slot_q[i].dn;
        end
    end

    assign rsp_acc = rsp_slot_q.acc;
    assign rsp_dn  = rsp_slot_q.dn;
    assign rsp_cu  = rsp_slot_q.cu;
    assign rsp_cd  = rsp_slot_q.cd;
    assign rsp_err = rsp_err_q;

endmodule

// File: tb/tb_counter_bank_ctrl.sv
// Directed bench for counter_bank_ctrl: vector table plus multi-cycle corner sequences.
module tb_counter_bank_ctrl;

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [2:0] cmd_idx;
    logic [1:0] cmd_type;
    logic [7:0] cmd_preset;
    logic       cmd_en;
    logic       rsp_valid;
    logic [7:0] rsp_acc;
    logic       rsp_dn;
    logic       rsp_cu;
    logic       rsp_cd;
    logic       rsp_err;
    logic [7:0] dn_vec;

    int n_cmp  = 0;
    int n_fail = 0;

    counter_bank_ctrl #(.NUM_CNT(8), .IDX_W(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_idx    (cmd_idx),
        .cmd_type   (cmd_type),
        .cmd_preset (cmd_preset),
        .cmd_en     (cmd_en),
        .rsp_valid  (rsp_valid),
        .rsp_acc    (rsp_acc),
        .rsp_dn     (rsp_dn),
        .rsp_cu     (rsp_cu),
        .rsp_cd     (rsp_cd),
        .rsp_err    (rsp_err),
        .dn_vec     (dn_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] op;
        logic [2:0] idx;
        logic [1:0] typ;
        logic [7:0] preset;
        logic       en;
        logic [7:0] acc;
        logic       dn;
        logic       cu;
        logic       cd;
        logic       err;
        logic [7:0] vec;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic [1:0] op, input logic [2:0] idx, input logic [1:0] typ,
                       input logic [7:0] preset, input logic en, input logic [7:0] acc,
                       input logic dn, input logic cu, input logic cd, input logic err,
                       input logic [7:0] vec);
        vec_t v;
        v.op = op; v.idx = idx; v.typ = typ; v.preset = preset; v.en = en;
        v.acc = acc; v.dn = dn; v.cu = cu; v.cd = cd; v.err = err; v.vec = vec;
        tbl.push_back(v);
    endtask

    // Issue one command and wait (bounded) for its response pulse.
    task automatic applyStimulus(input logic [1:0] op, input logic [2:0] idx, input logic [1:0] typ,
                                 input logic [7:0] preset, input logic en, output int lat,
                                 output logic ok);
        int waits;
        ok = 1'b0;
        lat = 0;
        @(negedge clk);
        waits = 0;
        while (!cmd_ready && waits < 10) begin
            @(negedge clk);
            waits++;
        end
        cmd_op = op; cmd_idx = idx; cmd_type = typ; cmd_preset = preset; cmd_en = en;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        lat = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            lat++;
        end
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL rsp_timeout: got no rsp_valid required rsp_valid within 10 cycles");
        end
    endtask

    task automatic checkOutput(input string tag, input vec_t v, input int lat);
        check({tag, ".latency"}, lat, 2);
        check({tag, ".acc"}, rsp_acc, v.acc);
        check({tag, ".dn"}, rsp_dn, v.dn);
        check({tag, ".cu"}, rsp_cu, v.cu);
        check({tag, ".cd"}, rsp_cd, v.cd);
        check({tag, ".err"}, rsp_err, v.err);
        check({tag, ".dn_vec"}, dn_vec, v.vec);
    endtask

    task automatic run_cmd(input string tag, input logic [1:0] op, input logic [2:0] idx,
                           input logic [1:0] typ, input logic [7:0] preset, input logic en,
                           input logic [7:0] acc, input logic dn, input logic cu, input logic cd,
                           input logic err, input logic [7:0] vec);
        vec_t v;
        int   lat;
        logic ok;
        v.op = op; v.idx = idx; v.typ = typ; v.preset = preset; v.en = en;
        v.acc = acc; v.dn = dn; v.cu = cu; v.cd = cd; v.err = err; v.vec = vec;
        applyStimulus(op, idx, typ, preset, en, lat, ok);
        if (ok) checkOutput(tag, v, lat);
    endtask

    initial begin
        int   lat;
        logic ok;
        int   pulses;

        reset = 1'b1;
        cmd_valid = 1'b0; cmd_op = '0; cmd_idx = '0; cmd_type = '0; cmd_preset = '0; cmd_en = 1'b0;
        #2;
        check("reset.cmd_ready", cmd_ready, 1);
        check("reset.rsp_valid", rsp_valid, 0);
        check("reset.rsp_acc", rsp_acc, 0);
        check("reset.rsp_flags", {rsp_dn, rsp_cu, rsp_cd, rsp_err}, 0);
        check("reset.dn_vec", dn_vec, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // op: 0 CONFIG, 1 COUNT, 2 RST, 3 READ
        add(0, 2, 2'b01, 3, 0,   0, 0, 0, 0, 0, 8'h00);
        add(1, 2, 0, 0, 1,       1, 0, 1, 0, 0, 8'h00);
        add(1, 2, 0, 0, 0,       1, 0, 0, 0, 0, 8'h00);
        add(1, 2, 0, 0, 1,       2, 0, 1, 0, 0, 8'h00);
        add(1, 2, 0, 0, 0,       2, 0, 0, 0, 0, 8'h00);
        add(1, 2, 0, 0, 1,       3, 1, 1, 0, 0, 8'h04);
        add(1, 2, 0, 0, 0,       3, 1, 0, 0, 0, 8'h04);
        add(1, 2, 0, 0, 1,       4, 1, 1, 0, 0, 8'h04);
        add(1, 2, 0, 0, 0,       4, 1, 0, 0, 0, 8'h04);
        add(0, 5, 2'b10, 2, 0,   2, 0, 0, 0, 0, 8'h04);
        add(1, 5, 0, 0, 1,       1, 0, 0, 1, 0, 8'h04);
        add(1, 5, 0, 0, 0,       1, 0, 0, 0, 0, 8'h04);
        add(1, 5, 0, 0, 1,       0, 1, 0, 1, 0, 8'h24);
        add(1, 5, 0, 0, 0,       0, 1, 0, 0, 0, 8'h24);
        add(1, 5, 0, 0, 1,       0, 1, 0, 1, 0, 8'h24);
        add(2, 5, 0, 0, 0,       2, 0, 0, 0, 0, 8'h04);
        add(1, 7, 0, 0, 1,       0, 0, 0, 0, 1, 8'h04);
        add(3, 7, 0, 0, 0,       0, 0, 0, 0, 1, 8'h04);
        add(2, 7, 0, 0, 0,       0, 0, 0, 0, 1, 8'h04);
        add(0, 7, 2'b11, 9, 0,   0, 0, 0, 0, 1, 8'h04);
        add(3, 7, 0, 0, 0,       0, 0, 0, 0, 1, 8'h04);
        add(0, 2, 2'b11, 7, 0,   4, 1, 0, 0, 1, 8'h04);
        add(3, 2, 0, 0, 0,       4, 1, 0, 0, 0, 8'h04);
        add(0, 0, 2'b01, 1, 0,   0, 0, 0, 0, 0, 8'h04);
        add(0, 1, 2'b10, 1, 0,   1, 0, 0, 0, 0, 8'h04);
        add(1, 0, 0, 0, 1,       1, 1, 1, 0, 0, 8'h05);
        add(1, 1, 0, 0, 1,       0, 1, 0, 1, 0, 8'h07);
        add(2, 0, 0, 0, 0,       0, 0, 0, 0, 0, 8'h06);
        add(3, 1, 0, 0, 0,       0, 1, 0, 1, 0, 8'h06);

        foreach (tbl[i]) begin
            applyStimulus(tbl[i].op, tbl[i].idx, tbl[i].typ, tbl[i].preset, tbl[i].en, lat, ok);
            if (ok) checkOutput($sformatf("vec%0d", i), tbl[i], lat);
        end

        // Rung held high: second COUNT sees no rising edge.
        run_cmd("hold1", 1, 2, 0, 0, 1, 5, 1, 1, 0, 0, 8'h06);
        run_cmd("hold2", 1, 2, 0, 0, 1, 5, 1, 1, 0, 0, 8'h06);

        // Up counter driven to all-ones, then one more edge must not wrap.
        run_cmd("sat.cfg", 0, 3, 2'b01, 8'd255, 0, 0, 0, 0, 0, 0, 8'h06);
        for (int k = 0; k < 255; k++) begin
            applyStimulus(1, 3, 0, 0, 1, lat, ok);
            applyStimulus(1, 3, 0, 0, 0, lat, ok);
        end
        run_cmd("sat.read", 3, 3, 0, 0, 0, 255, 1, 0, 0, 0, 8'h0E);
        run_cmd("sat.edge", 1, 3, 0, 0, 1, 255, 1, 1, 0, 0, 8'h0E);

        // cmd_valid held through EXEC/RESP: only one accept.
        @(negedge clk);
        cmd_op = 2'd3; cmd_idx = 3'd2; cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("held.exec_ready", cmd_ready, 0);
        check("held.exec_rsp", rsp_valid, 0);
        @(negedge clk);
        check("held.resp_valid", rsp_valid, 1);
        check("held.resp_ready", cmd_ready, 0);
        check("held.resp_acc", rsp_acc, 5);
        cmd_valid = 1'b0;
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (rsp_valid) pulses++;
        end
        check("held.extra_rsp", pulses, 0);
        check("held.idle_ready", cmd_ready, 1);

        // Reset during EXEC abandons the command and clears every slot.
        @(negedge clk);
        cmd_op = 2'd1; cmd_idx = 3'd2; cmd_en = 1'b0; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #2 reset = 1'b0;
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (rsp_valid) pulses++;
        end
        check("rstexec.rsp_pulses", pulses, 0);
        check("rstexec.dn_vec", dn_vec, 0);
        check("rstexec.ready", cmd_ready, 1);
        run_cmd("rstexec.read2", 3, 2, 0, 0, 0, 0, 0, 0, 0, 1, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
